// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// mem_req_arbiter
// Shares the single axi_rw request port between fetch and load/store paths.
// Revision: 1.0
// ============================================================================
module mem_req_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_valid_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic [1:0]          if_size_i,
  output logic                if_ready_o,
  output logic [DATA_W-1:0]   if_data_o,
  output logic [1:0]          if_resp_o,
  input  logic                mem_valid_i,
  input  logic                mem_write_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [1:0]          mem_size_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_strb_i,
  output logic                mem_ready_o,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic [1:0]          mem_resp_o,
  output logic                rw_valid_o,
  input  logic                rw_ready_i,
  output logic                rw_req_o,
  output logic [ADDR_W-1:0]   rw_addr_o,
  output logic [1:0]          rw_size_o,
  output logic [DATA_W-1:0]   rw_wdata_o,
  output logic [DATA_W/8-1:0] rw_strb_o,
  input  logic [DATA_W-1:0]   rw_rdata_i,
  input  logic [1:0]          rw_resp_i,
  output logic                busy_o
);

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state;
  logic   last_grant_mem;
  logic   grant_mem;
  logic   grant_if;

  // On a tie, round-robin favours whoever did not win last; fixed mode favours mem.
  assign grant_mem = mem_valid_i && (!if_valid_i || !RR_EN || !last_grant_mem);
  assign grant_if  = if_valid_i && !grant_mem;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last_grant_mem <= 1'b0;
      busy_o         <= 1'b0;
      rw_valid_o     <= 1'b0;
      rw_req_o       <= REQ_READ;
      rw_addr_o      <= '0;
      rw_size_o      <= '0;
      rw_wdata_o     <= '0;
      rw_strb_o      <= '0;
      if_ready_o     <= 1'b0;
      if_data_o      <= '0;
      if_resp_o      <= '0;
      mem_ready_o    <= 1'b0;
      mem_data_o     <= '0;
      mem_resp_o     <= '0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state      <= MEM_BUSY;
            busy_o     <= 1'b1;
            rw_valid_o <= 1'b1;
            rw_req_o   <= mem_write_i ? REQ_WRITE : REQ_READ;
            rw_addr_o  <= mem_addr_i;
            rw_size_o  <= mem_size_i;
            rw_wdata_o <= mem_wdata_i;
            rw_strb_o  <= mem_strb_i;
          end else if (grant_if) begin
            state      <= IF_BUSY;
            busy_o     <= 1'b1;
            rw_valid_o <= 1'b1;
            rw_req_o   <= REQ_READ;
            rw_addr_o  <= if_addr_i;
            rw_size_o  <= if_size_i;
            rw_wdata_o <= '0;
            rw_strb_o  <= '0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (rw_ready_i) begin
            state      <= DONE;
            rw_valid_o <= 1'b0;
            if (state == MEM_BUSY) begin
              mem_data_o     <= rw_rdata_i;
              mem_resp_o     <= rw_resp_i;
              mem_ready_o    <= 1'b1;
              last_grant_mem <= 1'b1;
            end else begin
              if_data_o      <= rw_rdata_i;
              if_resp_o      <= rw_resp_i;
              if_ready_o     <= 1'b1;
              last_grant_mem <= 1'b0;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_req_arbiter
// Directed and randomized checks of mem_req_arbiter against a transaction model.
// Revision: 1.0
// ============================================================================
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0, mem_valid = 1'b0, mem_write = 1'b0, rw_ready = 1'b0;
  logic [63:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, rw_rdata = '0;
  logic [1:0]  if_size = '0, mem_size = '0, rw_resp = '0;
  logic [7:0]  mem_strb = '0;

  logic        if_ready, mem_ready, rw_valid, rw_req, busy;
  logic [63:0] if_data, mem_data, rw_addr, rw_wdata;
  logic [1:0]  if_resp, mem_resp, rw_size;
  logic [7:0]  rw_strb;

  logic        f_if_ready, f_mem_ready, f_rw_valid, f_rw_req, f_busy;
  logic [63:0] f_if_data, f_mem_data, f_rw_addr, f_rw_wdata;
  logic [1:0]  f_if_resp, f_mem_resp, f_rw_size;
  logic [7:0]  f_rw_strb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b1)) dut (
    .clock(clk), .reset(rst),
    .if_valid_i(if_valid), .if_addr_i(if_addr), .if_size_i(if_size),
    .if_ready_o(if_ready), .if_data_o(if_data), .if_resp_o(if_resp),
    .mem_valid_i(mem_valid), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_size_i(mem_size), .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb),
    .mem_ready_o(mem_ready), .mem_data_o(mem_data), .mem_resp_o(mem_resp),
    .rw_valid_o(rw_valid), .rw_ready_i(rw_ready), .rw_req_o(rw_req),
    .rw_addr_o(rw_addr), .rw_size_o(rw_size), .rw_wdata_o(rw_wdata),
    .rw_strb_o(rw_strb), .rw_rdata_i(rw_rdata), .rw_resp_i(rw_resp),
    .busy_o(busy)
  );

  // Fixed-priority instance sees identical stimulus; only inspected on ties.
  mem_req_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b0)) dut_fixed (
    .clock(clk), .reset(rst),
    .if_valid_i(if_valid), .if_addr_i(if_addr), .if_size_i(if_size),
    .if_ready_o(f_if_ready), .if_data_o(f_if_data), .if_resp_o(f_if_resp),
    .mem_valid_i(mem_valid), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_size_i(mem_size), .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb),
    .mem_ready_o(f_mem_ready), .mem_data_o(f_mem_data), .mem_resp_o(f_mem_resp),
    .rw_valid_o(f_rw_valid), .rw_ready_i(rw_ready), .rw_req_o(f_rw_req),
    .rw_addr_o(f_rw_addr), .rw_size_o(f_rw_size), .rw_wdata_o(f_rw_wdata),
    .rw_strb_o(f_rw_strb), .rw_rdata_i(rw_rdata), .rw_resp_i(rw_resp),
    .busy_o(f_busy)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if ({rw_valid, busy, if_ready, mem_ready, rw_req} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {rw_valid, busy, if_ready, mem_ready, rw_req}); end
    checks++; if ({if_data, mem_data, if_resp, mem_resp} !== '0) begin errors++; $display("FAIL reset_data: got %h %h %h %h want 0", if_data, mem_data, if_resp, mem_resp); end
    checks++; if ({rw_addr, rw_wdata, rw_size, rw_strb} !== '0) begin errors++; $display("FAIL reset_rw_fields: got %h %h %h %h want 0", rw_addr, rw_wdata, rw_size, rw_strb); end
    rst = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_fetch;
    if_valid = 1'b1; if_addr = 64'h8000_0000; if_size = 2'd3;
    tick;
    checks++; if ({rw_valid, busy, rw_req} !== 3'b110) begin errors++; $display("FAIL fetch_issue: got valid,busy,req=%b want 110", {rw_valid, busy, rw_req}); end
    checks++; if (rw_addr !== 64'h8000_0000 || rw_size !== 2'd3 || rw_strb !== 8'h00) begin errors++; $display("FAIL fetch_fields: got %h %0d %h want 80000000 3 00", rw_addr, rw_size, rw_strb); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (rw_valid !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL fetch_wait: got valid=%b ready=%b want 1 0", rw_valid, if_ready); end
    end
    rw_ready = 1'b1; rw_rdata = 64'h0000_0013_0000_0093; rw_resp = 2'd0;
    tick;
    rw_ready = 1'b0; if_valid = 1'b0;
    checks++; if ({if_ready, mem_ready, rw_valid} !== 3'b100) begin errors++; $display("FAIL fetch_pulse: got if,mem,valid=%b want 100", {if_ready, mem_ready, rw_valid}); end
    checks++; if (if_data !== 64'h0000_0013_0000_0093 || if_resp !== 2'd0) begin errors++; $display("FAIL fetch_data: got %h resp %0d want 0000001300000093 0", if_data, if_resp); end
    tick;
    checks++; if ({if_ready, busy, rw_valid} !== 3'b000 || if_data !== 64'h0000_0013_0000_0093) begin errors++; $display("FAIL fetch_after: got r,b,v=%b data %h want 000 hold", {if_ready, busy, rw_valid}, if_data); end
  endtask

  task automatic test_store;
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 64'h8000_1004;
    mem_wdata = 64'hDEAD_BEEF; mem_strb = 8'hF0; mem_size = 2'd2;
    tick;
    checks++; if (rw_valid !== 1'b1 || rw_req !== 1'b1) begin errors++; $display("FAIL store_issue: got valid=%b req=%b want 1 1", rw_valid, rw_req); end
    for (int i = 0; i < 3; i++) begin
      mem_addr = {$urandom, $urandom}; mem_wdata = {$urandom, $urandom};
      mem_strb = 8'($urandom); mem_size = 2'($urandom); mem_write = 1'b0;
      tick;
      checks++; if (rw_addr !== 64'h8000_1004 || rw_wdata !== 64'hDEAD_BEEF || rw_strb !== 8'hF0 || rw_size !== 2'd2 || rw_req !== 1'b1 || rw_valid !== 1'b1) begin
        errors++; $display("FAIL store_stable: got %h %h %h %0d req=%b want 80001004 deadbeef f0 2 1", rw_addr, rw_wdata, rw_strb, rw_size, rw_req);
      end
    end
    rw_ready = 1'b1; rw_rdata = 64'h55AA; rw_resp = 2'd0;
    tick;
    rw_ready = 1'b0; mem_valid = 1'b0;
    checks++; if ({mem_ready, if_ready} !== 2'b10 || mem_data !== 64'h55AA || mem_resp !== 2'd0) begin errors++; $display("FAIL store_pulse: got mem,if=%b data %h resp %0d want 10 55aa 0", {mem_ready, if_ready}, mem_data, mem_resp); end
    tick;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL store_single_pulse: got %b want 0", mem_ready); end
  endtask

  task automatic test_tie;
    logic exp_mem;
    rst = 1'b1; tick;
    rst = 1'b0;
    if_valid = 1'b1; if_addr = 64'h1000; if_size = 2'd3;
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 64'h2000; mem_size = 2'd3;
    tick;
    for (int t = 0; t < 4; t++) begin
      exp_mem = (t % 2 == 0);
      checks++; if (rw_addr !== (exp_mem ? 64'h2000 : 64'h1000)) begin errors++; $display("FAIL tie_rr_grant%0d: got addr %h want %h", t, rw_addr, exp_mem ? 64'h2000 : 64'h1000); end
      checks++; if (f_rw_addr !== 64'h2000 || f_rw_valid !== 1'b1) begin errors++; $display("FAIL tie_fixed_grant%0d: got addr %h valid %b want 2000 1", t, f_rw_addr, f_rw_valid); end
      rw_ready = 1'b1; rw_rdata = 64'(t); rw_resp = 2'd0;
      tick;
      rw_ready = 1'b0;
      checks++; if ({mem_ready, if_ready} !== {exp_mem, !exp_mem}) begin errors++; $display("FAIL tie_rr_pulse%0d: got mem,if=%b want %b", t, {mem_ready, if_ready}, {exp_mem, !exp_mem}); end
      checks++; if (f_mem_ready !== 1'b1) begin errors++; $display("FAIL tie_fixed_pulse%0d: got %b want 1", t, f_mem_ready); end
      if (t == 3) begin if_valid = 1'b0; mem_valid = 1'b0; end
      tick; tick;
    end
    checks++; if (rw_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tie_drain: got valid=%b busy=%b want 0 0", rw_valid, busy); end
  endtask

  task automatic test_error;
    if_valid = 1'b1; if_addr = 64'h100; if_size = 2'd2;
    tick;
    rw_ready = 1'b1; rw_rdata = 64'hBAD; rw_resp = 2'b11;
    tick;
    rw_ready = 1'b0; if_valid = 1'b0;
    checks++; if (if_ready !== 1'b1 || if_resp !== 2'b11) begin errors++; $display("FAIL err_resp: got ready=%b resp=%0d want 1 3", if_ready, if_resp); end
    tick; tick;
    checks++; if (rw_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_no_retry: got valid=%b busy=%b want 0 0", rw_valid, busy); end
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 64'h200; mem_size = 2'd3;
    tick;
    checks++; if (rw_valid !== 1'b1 || rw_addr !== 64'h200 || rw_req !== 1'b0) begin errors++; $display("FAIL err_next_issue: got valid=%b addr %h req %b want 1 200 0", rw_valid, rw_addr, rw_req); end
    rw_ready = 1'b1; rw_rdata = 64'h77; rw_resp = 2'd0;
    tick;
    rw_ready = 1'b0; mem_valid = 1'b0;
    checks++; if (mem_ready !== 1'b1 || mem_data !== 64'h77 || if_resp !== 2'b11) begin errors++; $display("FAIL err_next_done: got ready=%b data %h if_resp %0d want 1 77 3", mem_ready, mem_data, if_resp); end
    tick;
  endtask

  task automatic test_reset_mid;
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 64'h300; mem_wdata = 64'h1; mem_strb = 8'hFF; mem_size = 2'd3;
    tick; tick;
    rst = 1'b1;
    tick;
    checks++; if ({rw_valid, mem_ready, busy} !== 3'b000 || rw_addr !== 64'h0 || mem_resp !== 2'd0) begin errors++; $display("FAIL rstmid_clear: got v,r,b=%b addr %h want 000 0", {rw_valid, mem_ready, busy}, rw_addr); end
    rst = 1'b0; mem_valid = 1'b0; mem_write = 1'b0;
    if_valid = 1'b1; if_addr = 64'h400; if_size = 2'd3;
    tick;
    checks++; if (rw_valid !== 1'b1 || rw_addr !== 64'h400) begin errors++; $display("FAIL rstmid_fetch_issue: got valid=%b addr %h want 1 400", rw_valid, rw_addr); end
    rw_ready = 1'b1; rw_rdata = 64'hABCD; rw_resp = 2'd0;
    tick;
    rw_ready = 1'b0; if_valid = 1'b0;
    checks++; if (if_ready !== 1'b1 || if_data !== 64'hABCD || mem_ready !== 1'b0) begin errors++; $display("FAIL rstmid_fetch_done: got ready=%b data %h mem_ready %b want 1 abcd 0", if_ready, if_data, mem_ready); end
    tick;
  endtask

  task automatic test_spurious;
    rw_ready = 1'b1; rw_rdata = 64'hFFFF; rw_resp = 2'd2;
    tick;
    rw_ready = 1'b0;
    checks++; if ({if_ready, mem_ready, busy, rw_valid} !== 4'b0000) begin errors++; $display("FAIL spurious_pulse: got %b want 0000", {if_ready, mem_ready, busy, rw_valid}); end
    checks++; if (if_data !== 64'hABCD || mem_data !== 64'h0 || if_resp !== 2'd0) begin errors++; $display("FAIL spurious_hold: got %h %h %0d want abcd 0 0", if_data, mem_data, if_resp); end
    tick;
    checks++; if ({if_ready, mem_ready, busy} !== 3'b000) begin errors++; $display("FAIL spurious_idle: got %b want 000", {if_ready, mem_ready, busy}); end
  endtask

  // Transaction-level model: one grant per IDLE, tie goes to the requester that did not win last.
  task automatic test_random;
    logic        if_pend, mem_pend, last_mem, win_mem;
    logic [63:0] e_if_data, e_mem_data, rdata;
    logic [1:0]  e_if_resp, e_mem_resp, resp;
    int          lat;
    rst = 1'b1; tick;
    rst = 1'b0;
    if_pend = 1'b0; mem_pend = 1'b0; last_mem = 1'b0;
    e_if_data = '0; e_mem_data = '0; e_if_resp = '0; e_mem_resp = '0;
    for (int it = 0; it < 40; it++) begin
      if (!if_pend && ($urandom % 2 == 0)) begin
        if_pend = 1'b1; if_addr = {$urandom, $urandom}; if_size = 2'($urandom);
      end
      if (!mem_pend && ($urandom % 2 == 0)) begin
        mem_pend = 1'b1; mem_write = 1'($urandom); mem_addr = {$urandom, $urandom};
        mem_size = 2'($urandom); mem_wdata = {$urandom, $urandom}; mem_strb = 8'($urandom);
      end
      if (!if_pend && !mem_pend) begin
        if_pend = 1'b1; if_addr = {$urandom, $urandom}; if_size = 2'($urandom);
      end
      if_valid = if_pend; mem_valid = mem_pend;
      win_mem = mem_pend && (!if_pend || !last_mem);
      tick;
      checks++; if (rw_valid !== 1'b1 || busy !== 1'b1 || rw_req !== (win_mem ? mem_write : 1'b0) || rw_addr !== (win_mem ? mem_addr : if_addr) || rw_size !== (win_mem ? mem_size : if_size) || rw_strb !== (win_mem ? mem_strb : 8'h00) || (win_mem && rw_wdata !== mem_wdata)) begin
        errors++; $display("FAIL rand_issue%0d: got v=%b req=%b addr %h size %0d strb %h want win_mem=%b", it, rw_valid, rw_req, rw_addr, rw_size, rw_strb, win_mem);
      end
      lat = int'($urandom % 4);
      repeat (lat) tick;
      rdata = {$urandom, $urandom}; resp = 2'($urandom);
      rw_ready = 1'b1; rw_rdata = rdata; rw_resp = resp;
      tick;
      rw_ready = 1'b0;
      if (win_mem) begin e_mem_data = rdata; e_mem_resp = resp; mem_pend = 1'b0; mem_valid = 1'b0; end
      else begin e_if_data = rdata; e_if_resp = resp; if_pend = 1'b0; if_valid = 1'b0; end
      last_mem = win_mem;
      checks++; if ({mem_ready, if_ready, rw_valid} !== {win_mem, !win_mem, 1'b0} || if_data !== e_if_data || if_resp !== e_if_resp || mem_data !== e_mem_data || mem_resp !== e_mem_resp) begin
        errors++; $display("FAIL rand_done%0d: got m,i,v=%b if %h/%0d mem %h/%0d want win_mem=%b if %h/%0d mem %h/%0d", it, {mem_ready, if_ready, rw_valid}, if_data, if_resp, mem_data, mem_resp, win_mem, e_if_data, e_if_resp, e_mem_data, e_mem_resp);
      end
      tick;
      checks++; if ({mem_ready, if_ready, busy, rw_valid} !== 4'b0000) begin errors++; $display("FAIL rand_idle%0d: got %b want 0000", it, {mem_ready, if_ready, busy, rw_valid}); end
    end
    if_valid = 1'b0; mem_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_store;
    test_tie;
    test_error;
    test_reset_mid;
    test_spurious;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
